bus_sequencer: RTL
==================

// Module: bus_sequencer
// PURPOSE
//  Control FSM for the simple processor's shared-bus datapath (R0..R7, A, ALU, G, tri-state bus1).
//  Accepts one instruction at a time over a valid/ready handshake.
//  Drives the bus buffer enables, register load enables, A/G strobes and ALU select for 1-3 cycles.
//  Pulses done on the final cycle. Guarantees at most one bus1 driver per cycle.
// PARAMETERS
//  DATA_W  16  width of immediate / bus1 data
//  NREG    8   number of general registers (one-hot enable width)
//  RA_W    3   register-address width (NREG = 2**RA_W)
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       asynchronous, active-low reset
//  instr_vld  in   1       instruction present
//  instr_rdy  out  1       sequencer can accept (IDLE and not trapped)
//  opcode     in   3       000 LOAD, 001 MOV, 010 ADD, 011 SUB, 100 XOR, 101 AND, 110 OR, 111 reserved
//  rx         in   RA_W    destination / first-operand register
//  ry         in   RA_W    source / second-operand register
//  imm        in   DATA_W  immediate for LOAD
//  data       out  DATA_W  registered immediate for the data tri-buffer
//  data_out   out  1       data tri-buffer enable
//  bus1_oe    out  NREG    register -> bus1 buffer enables; bit NREG-1 = R0, bit 0 = R7
//  reg_en     out  NREG    register load enables; same bit order
//  a_in       out  1       load A from bus1
//  g_in       out  1       load G from ALU
//  g_out      out  1       G -> bus1 buffer enable
//  math_en    out  7       one-hot ALU select: b0 ADD, b1 SUB, b2 XOR, b3 AND, b4 OR; b5, b6 always 0
//  done       out  1       one-cycle pulse on the last control cycle of an instruction
//  busy       out  1       state != IDLE
// BEHAVIOUR
//  Reset (async, rst=0): state IDLE; all outputs 0 except instr_rdy=1; data=0; captured instruction cleared.
//  Handshake: accept on the rising edge with instr_vld & instr_rdy.
//    opcode/rx/ry/imm are captured at that edge; inputs are don't-care afterwards.
//  All outputs are Moore, decoded from state plus the captured instruction. No combinational input->output path.
//  States: IDLE -> T1 -> (T2 -> T3) -> IDLE. T1 is the cycle after accept.
//  LOAD (T1 only):
//    T1: data_out=1, reg_en[rx]=1, done=1 -> IDLE.
//  MOV (T1 only):
//    T1: bus1_oe[ry]=1, reg_en[rx]=1, done=1 -> IDLE.
//  ALU ops ADD..OR:
//    T1: bus1_oe[rx]=1, a_in=1.
//    T2: bus1_oe[ry]=1, math_en[op]=1, g_in=1.
//    T3: g_out=1, reg_en[rx]=1, done=1 -> IDLE.
//  Latency, accept to done cycle: 1 for LOAD/MOV, 3 for ALU ops. Back-to-back accept is possible in the cycle after done.
//  rx==ry is legal:
//    MOV Rn,Rn leaves Rn unchanged.
//    ADD Rn,Rn doubles Rn.
//    SUB Rn,Rn clears Rn.
//  Every output not listed for a state is 0. Exactly zero or one of {data_out, bus1_oe[*], g_out} is high in any cycle.
//  Arithmetic is in the ALU. G holds the DATA_W-bit result modulo 2**DATA_W; the sequencer does no arithmetic.
//  Reset mid-instruction: immediate abort, no further enables, registers keep prior contents.
//  instr_vld while busy: ignored (instr_rdy=0); the source must hold the instruction.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined:
//    Opcode 111 accepted -> T1 asserts done=0 and sets sticky trap.
//    instr_rdy is held 0 until reset. Extra output port trap (1 bit) reflects the flag.
//  ILLEGAL_TRAP_EN undefined:
//    Opcode 111 is a NOP. T1 asserts only done=1 -> IDLE. No trap port.
// TESTING
//  1. Reset mid-ALU op (rst low in T2) -> all enables 0 in the same cycle, instr_rdy=1 after release, R* unchanged.
//  2. LOAD R3,#0x1234 -> T1: data_out=1, data=16'h1234, reg_en=8'b0001_0000, done=1. Display of R3 = 1234.
//  3. LOAD R0,#5; LOAD R1,#3; SUB R0,R1 -> T1 bus1_oe=8'h80 with a_in, T2 bus1_oe=8'h40 with math_en=7'b0000010, T3 g_out with reg_en=8'h80. R0=0002.
//  4. ADD R2,R2 with R2=16'h8001 -> R2=16'h0002 (wrap). Done exactly 3 cycles after accept.
//  5. Hold instr_vld with a MOV R7,R0 during an ALU op -> not accepted until the cycle after done. Then bus1_oe=8'h80, reg_en=8'h01.
//  6. Opcode 111 -> undefined: done pulse, next instr accepted. Defined: trap=1, instr_rdy stays 0 until rst.
//  All tests: a checker asserts at most one bus1 driver every cycle.

Source files
------------

// File: rtl/bus_sequencer.sv
// bus_sequencer: control FSM for the shared-bus datapath (R0..R7, A, ALU, G, bus1).
// Optional ILLEGAL_TRAP_EN: opcode 111 sets a sticky trap and blocks further instructions until reset.
module bus_sequencer #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    parameter int RA_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_vld,
    output logic              instr_rdy,
    input  logic [2:0]        opcode,
    input  logic [RA_W-1:0]   rx,
    input  logic [RA_W-1:0]   ry,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] data,
    output logic              data_out,
    output logic [NREG-1:0]   bus1_oe,
    output logic [NREG-1:0]   reg_en,
    output logic              a_in,
    output logic              g_in,
    output logic              g_out,
    output logic [6:0]        math_en,
    output logic              done,
`ifdef ILLEGAL_TRAP_EN
    output logic              trap,
`endif
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;

    state_t              state_q, state_d;
    logic [2:0]          op_q;
    logic [RA_W-1:0]     rx_q, ry_q;
    logic [DATA_W-1:0]   data_q;
    logic                trap_q;
    logic                accept, alu_op;

    assign accept = instr_vld & instr_rdy;
    assign alu_op = (op_q >= 3'd2) && (op_q <= 3'd6);

    // R0 sits in the MSB of the one-hot enable vectors
    function automatic logic [NREG-1:0] sel(input logic [RA_W-1:0] r);
        sel = NREG'(1) << (RA_W'(NREG - 1) - r);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            rx_q    <= '0;
            ry_q    <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q   <= opcode;
                rx_q   <= rx;
                ry_q   <= ry;
                data_q <= imm;
            end
        end
    end

`ifdef ILLEGAL_TRAP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) trap_q <= 1'b0;
        else      trap_q <= trap_q | (state_q == T1 && op_q == 3'b111);
    end
    assign trap = trap_q;
`else
    assign trap_q = 1'b0;
`endif

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = accept ? T1 : IDLE;
            T1:      state_d = alu_op ? T2 : IDLE;
            T2:      state_d = T3;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_out = 1'b0;
        bus1_oe  = '0;
        reg_en   = '0;
        a_in     = 1'b0;
        g_in     = 1'b0;
        g_out    = 1'b0;
        math_en  = '0;
        done     = 1'b0;
        case (state_q)
            T1: begin
                if (op_q == 3'd0) begin
                    data_out = 1'b1;
                    reg_en   = sel(rx_q);
                    done     = 1'b1;
                end else if (op_q == 3'd1) begin
                    bus1_oe  = sel(ry_q);
                    reg_en   = sel(rx_q);
                    done     = 1'b1;
                end else if (alu_op) begin
                    bus1_oe  = sel(rx_q);
                    a_in     = 1'b1;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    done     = 1'b0;
`else
                    done     = 1'b1;
`endif
                end
            end
            T2: begin
                bus1_oe = sel(ry_q);
                math_en = 7'd1 << (op_q - 3'd2);
                g_in    = 1'b1;
            end
            T3: begin
                g_out  = 1'b1;
                reg_en = sel(rx_q);
                done   = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign instr_rdy = (state_q == IDLE) && !trap_q;
    assign data      = data_q;
endmodule
